// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI receive-block path and its CRC helper.
package spi_rx_pkg;

    // Receive sequencer states; explicit encodings keep waveform compatibility.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HUNT = 3'd1,
        DATA = 3'd2,
        CRC  = 3'd3,
        DONE = 3'd4
    } rx_state_t;

    // Completion codes reported on o_status.
    typedef enum logic [1:0] {
        RX_OK        = 2'd0,
        RX_ERR_TOKEN = 2'd1,
        RX_CRC_BAD   = 2'd2,
        RX_TIMEOUT   = 2'd3
    } rx_status_t;

    localparam logic [7:0]  START_TOKEN    = 8'hfe;
    localparam logic [15:0] CRC_POLYNOMIAL = 16'h1021;

    // Block size exponent is limited to 8..512 byte blocks.
    function automatic logic [3:0] clamp_lgblksz(input logic [3:0] lg);
        if (lg < 4'd3) return 4'd3;
        if (lg > 4'd9) return 4'd9;
        return lg;
    endfunction

endpackage

// File: rtl/spirxblock_if.sv
// Byte-level handshake between the receive block and the shared SPI byte engine.
interface spirxblock_if;
    logic       o_ll_stb;
    logic [7:0] o_ll_byte;
    logic       i_ll_busy;
    logic       i_ll_stb;
    logic [7:0] i_ll_byte;

    modport master (
        output o_ll_stb, o_ll_byte,
        input  i_ll_busy, i_ll_stb, i_ll_byte
    );

    modport slave (
        input  o_ll_stb, o_ll_byte,
        output i_ll_busy, i_ll_stb, i_ll_byte
    );
endinterface

// File: rtl/spicrc16_byte.sv
// Combinational CRC16 update over one byte, MSB first, no reflection.
module spicrc16_byte
    import spi_rx_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_crc
);

    // Eight bit-serial LFSR steps unrolled into one cycle.
    always_comb begin
        o_crc = i_crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (o_crc[15] ^ i_byte[3'(7 - i)])
                o_crc = {o_crc[14:0], 1'b0} ^ CRC_POLYNOMIAL;
            else
                o_crc = {o_crc[14:0], 1'b0};
        end
    end

endmodule

// File: rtl/spirxblock.sv
// SPI data-block receiver: hunts for the start token, packs the block into
// buffer words and checks the trailing CRC16.
module spirxblock
    import spi_rx_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 8,
    parameter int MAX_WAIT = 1023,
    parameter int LGWAIT   = 10
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic [3:0]    i_lgblksz,
    input  logic          i_fifo,
    output logic          o_busy,
    output logic          o_write,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    spirxblock_if.master  ll,
    output logic          o_rxvalid,
    output logic [1:0]    o_status,
    output logic [7:0]    o_response
);

    rx_state_t         state_q, state_d;
    rx_status_t        status_q, status_d;
    logic              busy_q, busy_d;
    logic              write_q, write_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic              stb_q, stb_d;
    logic              pend_q, pend_d;
    logic              rxvalid_q, rxvalid_d;
    logic [7:0]        resp_q, resp_d;
    logic [LGWAIT-1:0] wcnt_q, wcnt_d;
    logic [9:0]        cnt_q, cnt_d;
    logic [3:0]        lg_q, lg_d;
    logic [DW-9:0]     sreg_q, sreg_d;
    logic [15:0]       crc_q, crc_d;
    logic [7:0]        crc_hi_q, crc_hi_d;
    logic [15:0]       crc_next;
    logic              rx_fire;

    spicrc16_byte u_crc (
        .i_crc  (crc_q),
        .i_byte (ll.i_ll_byte),
        .o_crc  (crc_next)
    );

    // Only a byte we actually requested is consumed; stray strobes are dropped.
    assign rx_fire = ll.i_ll_stb && pend_q;

    // Next-state logic: byte handshake, word packing and sequencing.
    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        busy_d    = busy_q;
        write_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        stb_d     = stb_q;
        pend_d    = pend_q;
        rxvalid_d = 1'b0;
        resp_d    = resp_q;
        wcnt_d    = wcnt_q;
        cnt_d     = cnt_q;
        lg_d      = lg_q;
        sreg_d    = sreg_q;
        crc_d     = crc_q;
        crc_hi_d  = crc_hi_q;

        // One byte in flight: request drops on acceptance, re-arms only once
        // the pending byte has returned (pend_q is still set on that edge).
        if (stb_q && !ll.i_ll_busy) begin
            stb_d  = 1'b0;
            pend_d = 1'b1;
        end
        if (rx_fire)
            pend_d = 1'b0;
        if (!stb_q && !pend_q && (state_q == HUNT || state_q == DATA || state_q == CRC))
            stb_d = 1'b1;

        // Word index advances after the write strobe; buffer select bit is kept.
        if (write_q)
            addr_d = {addr_q[AW-1], addr_q[AW-2:0] + 1'b1};

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    lg_d    = clamp_lgblksz(i_lgblksz);
                    addr_d  = {i_fifo, {(AW-1){1'b0}}};
                    wcnt_d  = '0;
                    crc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    stb_d   = 1'b1;
                    state_d = HUNT;
                end
            end
            HUNT: begin
                if (rx_fire) begin
                    if (ll.i_ll_byte == START_TOKEN) begin
                        resp_d  = START_TOKEN;
                        state_d = DATA;
                    end else if (ll.i_ll_byte[7:4] == 4'h0 && ll.i_ll_byte != 8'h00) begin
                        resp_d   = ll.i_ll_byte;
                        status_d = RX_ERR_TOKEN;
                        state_d  = DONE;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                        if (wcnt_d == LGWAIT'(MAX_WAIT)) begin
                            resp_d   = 8'hff;
                            status_d = RX_TIMEOUT;
                            state_d  = DONE;
                        end
                    end
                end
            end
            DATA: begin
                if (rx_fire) begin
                    sreg_d = {sreg_q[DW-17:0], ll.i_ll_byte};
                    crc_d  = crc_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q[1:0] == 2'd3) begin
                        write_d = 1'b1;
                        data_d  = {sreg_q, ll.i_ll_byte};
                    end
                    if (cnt_d == (10'd1 << lg_q)) begin
                        cnt_d   = '0;
                        state_d = CRC;
                    end
                end
            end
            CRC: begin
                if (rx_fire) begin
                    if (!cnt_q[0]) begin
                        crc_hi_d = ll.i_ll_byte;
                        cnt_d    = 10'd1;
                    end else begin
                        status_d = ({crc_hi_q, ll.i_ll_byte} == crc_q) ? RX_OK : RX_CRC_BAD;
                        resp_d   = START_TOKEN;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                rxvalid_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            status_q  <= RX_OK;
            busy_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            stb_q     <= 1'b0;
            pend_q    <= 1'b0;
            rxvalid_q <= 1'b0;
            resp_q    <= 8'hff;
            wcnt_q    <= '0;
            cnt_q     <= '0;
            lg_q      <= 4'd3;
            sreg_q    <= '0;
            crc_q     <= '0;
            crc_hi_q  <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            busy_q    <= busy_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            stb_q     <= stb_d;
            pend_q    <= pend_d;
            rxvalid_q <= rxvalid_d;
            resp_q    <= resp_d;
            wcnt_q    <= wcnt_d;
            cnt_q     <= cnt_d;
            lg_q      <= lg_d;
            sreg_q    <= sreg_d;
            crc_q     <= crc_d;
            crc_hi_q  <= crc_hi_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_write      = write_q;
    assign o_addr       = addr_q;
    assign o_data       = data_q;
    assign o_rxvalid    = rxvalid_q;
    assign o_status     = status_q;
    assign o_response   = resp_q;
    assign ll.o_ll_stb  = stb_q;
    assign ll.o_ll_byte = 8'hff;

endmodule
